instr_fetch_buffer: RTL and testbench

Fetch-side buffer between the prefetch address stage and decode. Accepts one fetch address per cycle from the prefetch stage and tracks the outstanding instruction-RAM read. Captures the returned instruction word with its PC into a small FIFO and presents it to decode on a valid/ready handshake. Provides backpressure to the prefetch stage and discards in-flight and buffered instructions on a redirect flush.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/instr_fetch_buffer.sv | 86 ++++++++
 tb/tb_instr_fetch_buffer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch buffer.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN  = 32;
  localparam int unsigned FETCH_DEPTH = 4;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
    logic                  err;
  } fetch_entry_t;

  function automatic logic pc_misaligned(input logic [FETCH_XLEN-1:0] pc);
    return |pc[1:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; clear overrides push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  fetch_entry_t               data_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output fetch_entry_t               head_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic          do_pop;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    do_pop = pop_i && (cnt_q != '0);
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wptr_q] = data_i;
        wptr_d        = wptr_q + PW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      case ({push_i, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch buffer: tracks the one-cycle RAM read, queues {pc, instr, err} for decode.
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH,
  parameter int unsigned XLEN  = FETCH_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            addr_valid_i,
  input  logic [XLEN-1:0] addr_i,
  output logic            fetch_ready_o,
  input  logic [XLEN-1:0] instr_rdata_i,
  input  logic            flush_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            instr_err_o,
  input  logic            instr_ready_i
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = CW + 1;

  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pend_err_q, pend_err_d;

  logic [CW-1:0]   count;
  logic [SW-1:0]   credit_used;
  logic            accept;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // The in-flight read holds a slot, so a capture can never overflow the FIFO.
  assign credit_used   = SW'(count) + SW'(pend_valid_q);
  assign fetch_ready_o = rst_ni && !flush_i && (credit_used < SW'(DEPTH));
  assign accept        = addr_valid_i && fetch_ready_o;

  always_comb begin
    pend_valid_d = accept;
    pend_pc_d    = pend_pc_q;
    pend_err_d   = pend_err_q;
    if (accept) begin
      pend_pc_d  = addr_i;
      pend_err_d = pc_misaligned(addr_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      pend_err_q   <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      pend_err_q   <= pend_err_d;
    end
  end

  assign push       = pend_valid_q && !flush_i;
  assign pop        = instr_valid_o && instr_ready_i;
  assign push_entry = '{pc: pend_pc_q, instr: instr_rdata_i, err: pend_err_q};

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(flush_i),
    .push_i (push),
    .pop_i  (pop),
    .data_i (push_entry),
    .count_o(count),
    .head_o (head)
  );

  assign instr_valid_o = (count != '0);
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;
  assign instr_err_o   = head.err;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Scoreboard bench: accepts push expected entries, a negedge monitor pops and compares.
module tb_instr_fetch_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        addr_valid = 1'b0;
  logic [31:0] addr = '0;
  logic        fetch_ready;
  logic [31:0] ram_q = '0;
  logic        flush = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_err;
  logic        instr_ready = 1'b0;

  int   vecs = 0;
  int   errs = 0;
  exp_t q[$];
  int   m_cnt = 0;
  int   m_pend = 0;
  int   acc_cnt = 0;
  logic acc_fire = 1'b0;
  logic [31:0] next_addr = '0;

  instr_fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .addr_valid_i (addr_valid),
    .addr_i       (addr),
    .fetch_ready_o(fetch_ready),
    .instr_rdata_i(ram_q),
    .flush_i      (flush),
    .instr_valid_o(instr_valid),
    .instr_o      (instr),
    .instr_pc_o   (instr_pc),
    .instr_err_o  (instr_err),
    .instr_ready_i(instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic m_ready();
    return rst_n && !flush && ((m_cnt + m_pend) < DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: credit model, RAM with 1-cycle read, expected-entry queue.
  task automatic model_loop();
    logic acc, pop, push;
    exp_t e;
    forever begin
      @(posedge clk);
      ram_q <= addr ^ KEY;
      acc = addr_valid && m_ready();
      if (!rst_n || flush) begin
        m_cnt  = 0;
        m_pend = 0;
        q.delete();
        acc_fire = 1'b0;
      end else begin
        pop  = (m_cnt != 0) && instr_ready;
        push = (m_pend != 0);
        m_cnt = m_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
        m_pend = acc ? 1 : 0;
        acc_fire = acc;
        if (acc) begin
          e.pc    = addr;
          e.instr = addr ^ KEY;
          e.err   = (addr[1:0] != 2'b00);
          q.push_back(e);
          acc_cnt++;
        end
      end
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("fetch_ready", 32'(fetch_ready), 32'(m_ready()));
      chk("instr_valid", 32'(instr_valid), 32'(m_cnt != 0));
      if (instr_valid === 1'b1 && instr_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_entry_pc", instr_pc, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("head_pc", instr_pc, e.pc);
          chk("head_instr", instr, e.instr);
          chk("head_err", 32'(instr_err), 32'(e.err));
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic rdy, input logic fl, input logic rs);
    addr_valid  = v;
    instr_ready = rdy;
    flush       = fl;
    rst_n       = rs;
    addr        = next_addr;
    @(posedge clk);
    #1;
    if (acc_fire) next_addr = next_addr + 32'd4;
  endtask

  initial begin
    int a0;
    fork
      model_loop();
      monitor_loop();
    join_none

    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", 32'(fetch_ready), 32'd1);
    chk("post_reset_valid", 32'(instr_valid), 32'd0);

    // Streaming from 0x0 with decode always ready.
    next_addr = 32'h0;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("first_valid_pc", instr_pc, 32'h0);
    chk("first_valid", 32'(instr_valid), 32'd1);
    repeat (8) step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);

    // Backpressure: four accepts fill FIFO plus in-flight slot.
    a0 = acc_cnt;
    repeat (7) step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("bp_accepts", 32'(acc_cnt - a0), 32'd4);
    chk("bp_ready_low", 32'(fetch_ready), 32'd0);
    a0 = acc_cnt;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("one_pop_one_accept", 32'(acc_cnt - a0), 32'd1);
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("drained", 32'(instr_valid), 32'd0);

    // Flush with 3 buffered and 1 in flight, then refetch from 0x100.
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("flush_valid", 32'(instr_valid), 32'd0);
    next_addr = 32'h100;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("refetch_valid", 32'(instr_valid), 32'd1);
    chk("refetch_pc", instr_pc, 32'h100);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);

    // Concurrent push/pop at count 2; pointers wrap several times.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("steady_ready", 32'(fetch_ready), 32'd1);
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b1);

    // Misaligned PC between aligned neighbours.
    next_addr = 32'hF8;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    next_addr = 32'h102;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    next_addr = 32'h104;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("misaligned_pc", instr_pc, 32'h102);
    chk("misaligned_err", 32'(instr_err), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b1);

    // Reset mid-stream with entries buffered and a read in flight.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_ready_low", 32'(fetch_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready_high", 32'(fetch_ready), 32'd1);
    next_addr = 32'h200;
    repeat (6) step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
